pattern_match_sequencer: RTL and testbench
==========================================

// Module: pattern_match_sequencer
// PURPOSE
//  Control block for the 16-bit pattern detector path. Holds NPAT programmable
//  pattern slots; each slot has a care-mask, so masked bits act as '?' wildcards.
//  Accepts one data word per valid/ready handshake and compares it against the
//  enabled slots, one slot per cycle, lowest index first.
//  Returns hit/miss and the index of the first matching slot on a valid/ready output.
// PARAMETERS
//  W     16  data / pattern width in bits
//  NPAT  4   number of pattern slots (>=2)
//  IDXW  2   slot index width, = clog2(NPAT)
// PORTS
//  clk       in   1     single clock, all state updates on rising edge
//  rst_n     in   1     asynchronous, active-low reset
//  cfg_we    in   1     write slot cfg_idx this edge
//  cfg_idx   in   IDXW  slot to write
//  cfg_pat   in   W     pattern value
//  cfg_mask  in   W     care mask (1 = bit compared, 0 = don't care)
//  cfg_en    in   1     slot enable written with pattern
//  in_valid  in   1     input word valid
//  in_ready  out  1     block can accept a word
//  in_data   in   W     word to classify
//  out_valid out  1     result valid
//  out_ready in   1     consumer takes result
//  out_hit   out  1     1 = some enabled slot matched
//  out_idx   out  IDXW  first matching slot (0 on miss)
//  busy      out  1     state != IDLE
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE; ptr=0; out_valid=0, out_hit=0,
//   out_idx=0, busy=0, in_ready=1 once reset is released; all slots pat=0, mask=0, en=0.
//  Match rule: slot s matches iff en[s] && ((data ^ pat[s]) & mask[s]) == 0.
//   An enabled slot with mask=0 matches every word.
//  FSM:
//   IDLE: in_ready=1. On in_valid&&in_ready: latch in_data, ptr<=0, ->SCAN.
//   SCAN: in_ready=0. Compare latched word against slot ptr.
//     match    -> out_hit<=1, out_idx<=ptr, ->DONE
//     no match, ptr==NPAT-1 -> out_hit<=0, out_idx<=0, ->DONE
//     otherwise ptr<=ptr+1, stay in SCAN.
//   DONE: out_valid=1 and in_ready=0. out_hit/out_idx stay stable until the
//     output handshake. On out_ready: ->IDLE. in_ready rises in the next cycle
//     (no bypass).
//  Latency: accept edge E0. First hit at slot k -> out_valid high after edge
//   E0+k+1. Miss -> out_valid high after edge E0+NPAT.
//   Minimum turnaround is k+3 cycles per word.
//  Config: table writes take effect at the write edge. A SCAN compare in the
//   same cycle uses the old slot contents. Writes are legal in any state.
//   An out-of-range cfg_idx (NPAT not a power of 2) is ignored.
//  in_data changes while not in_ready are ignored; the word is latched only at
//   acceptance.
//  rst_n asserted mid-SCAN or mid-DONE aborts the word. No result is emitted.
// TESTING
//  1 Reset, then in_valid with no slot enabled -> out_valid after 4 cycles,
//    out_hit=0, out_idx=0.
//  2 slot2 = {pat 16'hA5C3, mask 16'hFFFF, en 1}; send 16'hA5C3 -> out_valid
//    after 3 cycles, out_hit=1, out_idx=2. Send 16'hA5C2 -> out_hit=0.
//  3 slot1 = {pat 16'h1200, mask 16'hFF00}, slot3 = {mask 0} (matches all);
//    send 16'h12EF -> idx=1. Send 16'h3400 -> idx=3.
//  4 Hold out_ready=0 for 5 cycles: out_valid and out_idx stay stable, in_ready
//    stays 0. Raise out_ready -> IDLE, and in_ready=1 on the following cycle.
//  5 Rewrite slot0 to a matching pattern at the SCAN edge that compares slot0:
//    old contents are used (miss on slot0).
//  6 Assert rst_n low during SCAN -> outputs cleared immediately; the next word
//    misses because the table was cleared.

Source files
------------

// File: rtl/pattern_match_sequencer.sv
// Pattern detector control: classifies one word per handshake against NPAT
// masked pattern slots, scanning one slot per cycle from index 0 upward.
module pattern_match_sequencer #(
  parameter int W    = 16,
  parameter int NPAT = 4,
  parameter int IDXW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [IDXW-1:0] cfg_idx,
  input  logic [W-1:0]    cfg_pat,
  input  logic [W-1:0]    cfg_mask,
  input  logic            cfg_en,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_hit,
  output logic [IDXW-1:0] out_idx,
  output logic            busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NPAT - 1);

  state_e          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [W-1:0]    data_q, data_d;
  logic            out_hit_q, out_hit_d;
  logic [IDXW-1:0] out_idx_q, out_idx_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;

  logic [W-1:0]    pat_q  [NPAT];
  logic [W-1:0]    pat_d  [NPAT];
  logic [W-1:0]    mask_q [NPAT];
  logic [W-1:0]    mask_d [NPAT];
  logic [NPAT-1:0] en_q, en_d;

  logic            cfg_in_range_s;
  logic            cur_match_s;

  // A cleared mask bit turns that bit position into a wildcard.
  function automatic logic slot_match(input logic [W-1:0] data,
                                      input logic [W-1:0] pat,
                                      input logic [W-1:0] mask,
                                      input logic         en);
    return en && (((data ^ pat) & mask) == {W{1'b0}});
  endfunction

  assign cfg_in_range_s = ({{(32-IDXW){1'b0}}, cfg_idx} < $unsigned(NPAT));
  assign cur_match_s    = slot_match(data_q, pat_q[ptr_q], mask_q[ptr_q], en_q[ptr_q]);

  // Slot table next-state: a write lands at the edge, so a compare in the
  // same cycle still sees the old contents.
  always_comb begin
    en_d = en_q;
    for (int s = 0; s < NPAT; s++) begin
      if (cfg_we && cfg_in_range_s && (cfg_idx == IDXW'(s))) begin
        pat_d[s]  = cfg_pat;
        mask_d[s] = cfg_mask;
        en_d[s]   = cfg_en;
      end else begin
        pat_d[s]  = pat_q[s];
        mask_d[s] = mask_q[s];
        en_d[s]   = en_q[s];
      end
    end
  end

  // Slot table registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NPAT; s++) begin
        pat_q[s]  <= {W{1'b0}};
        mask_q[s] <= {W{1'b0}};
      end
      en_q <= {NPAT{1'b0}};
    end else begin
      for (int s = 0; s < NPAT; s++) begin
        pat_q[s]  <= pat_d[s];
        mask_q[s] <= mask_d[s];
      end
      en_q <= en_d;
    end
  end

  // Sequencer next-state and result capture.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    out_hit_d = out_hit_q;
    out_idx_d = out_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          data_d  = in_data;
          ptr_d   = {IDXW{1'b0}};
          state_d = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (cur_match_s) begin
          out_hit_d = 1'b1;
          out_idx_d = ptr_q;
          state_d   = ST_DONE;
        end else if (ptr_q == LAST_IDX) begin
          out_hit_d = 1'b0;
          out_idx_d = {IDXW{1'b0}};
          state_d   = ST_DONE;
        end else begin
          ptr_d   = ptr_q + IDXW'(1);
          state_d = ST_SCAN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = {IDXW{1'b0}};
      end
    endcase
    // Handshake flags are registered from the next state, so in_ready only
    // rises the cycle after the result is consumed.
    out_valid_d = (state_d == ST_DONE);
    in_ready_d  = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= {IDXW{1'b0}};
      data_q      <= {W{1'b0}};
      out_hit_q   <= 1'b0;
      out_idx_q   <= {IDXW{1'b0}};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      data_q      <= data_d;
      out_hit_q   <= out_hit_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_hit   = out_hit_q;
  assign out_idx   = out_idx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pattern_match_sequencer.sv
// Scoreboard bench for pattern_match_sequencer: expected hit/idx/latency come
// from a first-match search over a model slot table.
module tb_pattern_match_sequencer;
  localparam int W    = 16;
  localparam int NPAT = 4;
  localparam int IDXW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_we = 1'b0;
  logic [IDXW-1:0] cfg_idx = '0;
  logic [W-1:0]    cfg_pat = '0;
  logic [W-1:0]    cfg_mask = '0;
  logic            cfg_en = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            out_hit;
  logic [IDXW-1:0] out_idx;
  logic            busy;

  pattern_match_sequencer #(.W(W), .NPAT(NPAT), .IDXW(IDXW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_pat(cfg_pat), .cfg_mask(cfg_mask), .cfg_en(cfg_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
    .out_idx(out_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            hit;
    logic [IDXW-1:0] idx;
    logic [31:0]     lat;
  } exp_t;

  exp_t        exp_q[$];
  int          acc_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          rdy_mode = 0;
  bit          lat_done = 1'b0;
  logic [W-1:0] m_pat  [NPAT];
  logic [W-1:0] m_mask [NPAT];
  logic         m_en   [NPAT];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] d);
    exp_t e;
    e.hit = 1'b0; e.idx = '0; e.lat = NPAT;
    for (int s = NPAT - 1; s >= 0; s--) begin
      if (m_en[s] && (((d ^ m_pat[s]) & m_mask[s]) == '0)) begin
        e.hit = 1'b1; e.idx = s[IDXW-1:0]; e.lat = s + 1;
      end
    end
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: latency from acceptance to out_valid, result on output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      lat_done = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_q.push_back(cyc + 1);
      if (out_valid && !lat_done) begin
        lat_done = 1'b1;
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          int a;
          a = acc_q.pop_front();
          check("latency", cyc - a, exp_q[0].lat);
          check("busy_in_done", {31'd0, busy}, 32'd1);
          check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
        end
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_hit", {31'd0, out_hit}, {31'd0, e.hit});
        check("out_idx", {30'd0, out_idx}, {30'd0, e.idx});
        lat_done = 1'b0;
      end
    end
  end

  task automatic cfg_write_now(input int idx, input logic [W-1:0] p, input logic [W-1:0] m, input logic en);
    cfg_we = 1'b1; cfg_idx = idx[IDXW-1:0]; cfg_pat = p; cfg_mask = m; cfg_en = en;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_pat[idx] = p; m_mask[idx] = m; m_en[idx] = en;
  endtask

  task automatic cfg_write(input int idx, input logic [W-1:0] p, input logic [W-1:0] m, input logic en);
    @(posedge clk); #1;
    cfg_write_now(idx, p, m, en);
  endtask

  task automatic send_word(input logic [W-1:0] d);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      check("in_ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(model(d));
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = W'($urandom);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      check("result_timeout", exp_q.size(), 32'd0);
      exp_q.delete(); acc_q.delete();
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < NPAT; s++) begin
      m_pat[s] = '0; m_mask[s] = '0; m_en[s] = 1'b0;
    end
  endtask

  initial begin
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_hit", {31'd0, out_hit}, 32'd0);
    check("rst_out_idx", {30'd0, out_idx}, 32'd0);

    // No slots enabled: full-length miss.
    send_word(16'h0000);
    wait_idle();

    cfg_write(2, 16'hA5C3, 16'hFFFF, 1'b1);
    send_word(16'hA5C3);
    send_word(16'hA5C2);
    wait_idle();

    cfg_write(1, 16'h1200, 16'hFF00, 1'b1);
    cfg_write(3, 16'h0000, 16'h0000, 1'b1);
    send_word(16'h12EF);
    send_word(16'h3400);
    wait_idle();

    // Back-pressure: result must hold while out_ready stays low.
    rdy_mode = 1;
    @(posedge clk);
    send_word(16'h12EF);
    for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_out_idx", {30'd0, out_idx}, 32'd1);
    end
    rdy_mode = 0;
    @(posedge clk);
    @(negedge clk);
    check("pre_hs_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
    wait_idle();

    // Rewrite slot0 at the very edge that compares slot0.
    cfg_write(1, 16'h0000, 16'h0000, 1'b0);
    cfg_write(2, 16'h0000, 16'h0000, 1'b0);
    cfg_write(3, 16'h0000, 16'h0000, 1'b0);
    send_word(16'h5A5A);
    cfg_write_now(0, 16'h5A5A, 16'hFFFF, 1'b1);
    wait_idle();
    send_word(16'h5A5A);
    wait_idle();

    // Randomized traffic with random back-pressure.
    rdy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      int s;
      logic [W-1:0] d;
      logic [W-1:0] m;
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        case ($urandom_range(0, 4))
          0:       m = 16'hFFFF;
          1:       m = 16'hFF00;
          2:       m = 16'h0F0F;
          3:       m = 16'h0000;
          default: m = W'($urandom);
        endcase
        cfg_write($urandom_range(0, NPAT - 1), W'($urandom), m, 1'($urandom_range(0, 3) != 0));
      end
      s = $urandom_range(0, NPAT - 1);
      if ($urandom_range(0, 1) == 1) begin
        d = m_pat[s] ^ (W'($urandom) & ~m_mask[s]);
        if ($urandom_range(0, 3) == 0) d = d ^ (W'(1) << $urandom_range(0, W - 1));
      end else begin
        d = W'($urandom);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send_word(d);
    end
    wait_idle();
    rdy_mode = 0;

    // Reset in the middle of a scan aborts the word and clears the table.
    cfg_write(0, 16'h0000, 16'h0000, 1'b0);
    cfg_write(3, 16'h0000, 16'h0000, 1'b1);
    cfg_write(1, 16'h0000, 16'h0000, 1'b0);
    cfg_write(2, 16'h0000, 16'h0000, 1'b0);
    send_word(16'h1234);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_out_hit", {31'd0, out_hit}, 32'd0);
    check("abort_out_idx", {30'd0, out_idx}, 32'd0);
    exp_q.delete();
    acc_q.delete();
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort_out_valid_after", {31'd0, out_valid}, 32'd0);
    check("rerst_in_ready", {31'd0, in_ready}, 32'd1);
    send_word(16'h1234);
    wait_idle();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
